// File: rtl/mem_burst_master.sv
// mem_burst_master: one-at-a-time cache-line fill/writeback initiator over mem_itf, BURST_LEN beats paced by mem_resp.
module mem_burst_master #(
  parameter int BURST_LEN        = 4,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int TIMEOUT          = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [31:0]                 req_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] req_wline,
  output logic                        rsp_valid,
  output logic                        rsp_err,
  output logic [CACHE_LINE_WIDTH-1:0] rsp_rline,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [31:0]                 mem_address,
  output logic [31:0]                 mem_wdata,
  output logic [3:0]                  mem_byte_enable,
  input  logic [31:0]                 mem_rdata,
  input  logic                        mem_resp
);
  localparam int BW     = CACHE_LINE_WIDTH / BURST_LEN;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int TCNT_W = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [CACHE_LINE_WIDTH-1:0] wline_q, wline_d, rbuf_q, rbuf_d, rline_q, rline_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wline_q <= '0;
      rbuf_q  <= '0;
      rline_q <= '0;
      beat_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rbuf_q  <= rbuf_d;
      rline_q <= rline_d;
      beat_q  <= beat_d;
      tcnt_q  <= tcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rbuf_d  = rbuf_q;
    rline_d = rline_q;
    beat_d  = beat_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        state_d = BUSY;
        wr_d    = req_write;
        err_d   = 1'b0;
        addr_d  = req_addr & ~32'(CACHE_LINE_WIDTH / 8 - 1);
        wline_d = req_wline;
        beat_d  = '0;
        tcnt_d  = '0;
      end
      BUSY: if (mem_resp) begin
        rbuf_d = (rbuf_q & ~(CACHE_LINE_WIDTH'({BW{1'b1}}) << (BW * beat_q)))
               | (CACHE_LINE_WIDTH'(mem_rdata) << (BW * beat_q));
        beat_d = beat_q + 1'b1;
        tcnt_d = '0;
        if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
          state_d = RESP;
          // publish the whole line in the same edge that raises rsp_valid
          rline_d = wr_q ? rline_q : rbuf_d;
        end
      end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
        state_d = RESP;
        err_d   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready       = state_q == IDLE;
    rsp_valid       = state_q == RESP;
    rsp_err         = state_q == RESP && err_q;
    rsp_rline       = rline_q;
    mem_read        = state_q == BUSY && !wr_q;
    mem_write       = state_q == BUSY && wr_q;
    mem_address     = addr_q;
    mem_wdata       = BW'(wline_q >> (BW * beat_q));
    mem_byte_enable = 4'hF;
  end
endmodule
